// File: rtl/prog_bool_lut_pkg.sv
// prog_bool_lut_pkg: shared config FSM encoding, hit counter constants and width helpers
package prog_bool_lut_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} cfg_state_e;

    localparam int HIT_W = 16;
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    function automatic int tt_w(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int ch_w(input int n_ch);
        return n_ch > 1 ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/prog_bool_lut_if.sv
// prog_bool_lut_if: evaluation stream and serial configuration port of prog_bool_lut
interface prog_bool_lut_if #(
    parameter int N_IN = 4,
    parameter int N_CH = 2
);
    import prog_bool_lut_pkg::*;

    localparam int CH_W = ch_w(N_CH);

    logic                   in_valid;
    logic                   in_ready;
    logic [N_CH*N_IN-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_CH-1:0]        out_data;
    logic                   cfg_start;
    logic [CH_W-1:0]        cfg_ch;
    logic                   cfg_bit_valid;
    logic                   cfg_bit;
    logic                   cfg_busy;
    logic                   cfg_done;

    modport master (
        output in_valid, in_data, out_ready, cfg_start, cfg_ch, cfg_bit_valid, cfg_bit,
        input  in_ready, out_valid, out_data, cfg_busy, cfg_done
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_start, cfg_ch, cfg_bit_valid, cfg_bit,
        output in_ready, out_valid, out_data, cfg_busy, cfg_done
    );

endinterface

// File: rtl/prog_bool_lut_cell.sv
// bool_lut_cell: one channel's active truth table with commit write port and index mux
module bool_lut_cell
    import prog_bool_lut_pkg::*;
#(
    parameter int                       N_IN = 4,
    parameter logic [tt_w(N_IN)-1:0]    INIT = 16'hFF91
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [tt_w(N_IN)-1:0]   wdata,
    input  logic [N_IN-1:0]         idx,
    output logic                    y
);

    logic [tt_w(N_IN)-1:0] tt_q, tt_d;

    always_comb tt_d = we ? wdata : tt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tt_q <= INIT;
        else        tt_q <= tt_d;

    assign y = tt_q[idx];

endmodule

// File: rtl/prog_bool_lut.sv
// prog_bool_lut: N_CH-channel programmable LUT with serial table reload; PROG_BOOL_LUT_HITCNT_EN adds per-channel hit counters
module prog_bool_lut
    import prog_bool_lut_pkg::*;
#(
    parameter int                       N_IN       = 4,
    parameter int                       N_CH       = 2,
    parameter logic [tt_w(N_IN)-1:0]    DEFAULT_TT = 16'hFF91
) (
    input  logic                    clk,
    input  logic                    rst_n,
    prog_bool_lut_if.slave          bus
`ifdef PROG_BOOL_LUT_HITCNT_EN
    ,
    input  logic                    hit_clr,
    output logic [N_CH*HIT_W-1:0]   hit_cnt
`endif
);

    localparam int TT_W  = tt_w(N_IN);
    localparam int CH_W  = ch_w(N_CH);
    localparam int IW    = $clog2(TT_W);
    localparam int CNT_W = IW + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TT_W - 1);

    cfg_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [TT_W-1:0]    shadow_q, shadow_d;
    logic               out_valid_q, out_valid_d;
    logic [N_CH-1:0]    out_data_q, out_data_d;
    logic [N_CH-1:0]    y, we;
    logic               accept;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.cfg_busy  = state_q != IDLE;
    assign bus.cfg_done  = state_q == COMMIT;

    // COMMIT ignores cfg_start; in LOAD a new start discards the partial table
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        if (state_q == COMMIT) begin
            state_d = IDLE;
        end else if (bus.cfg_start) begin
            state_d  = LOAD;
            cnt_d    = '0;
            ch_d     = bus.cfg_ch;
            shadow_d = '0;
        end else if (state_q == LOAD && bus.cfg_bit_valid) begin
            shadow_d[cnt_q[IW-1:0]] = bus.cfg_bit;
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == LAST ? COMMIT : LOAD;
        end
    end

    always_comb begin
        out_valid_d = accept || (out_valid_q && !bus.out_ready);
        out_data_d  = accept ? y : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ch_q        <= '0;
            shadow_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            shadow_q    <= shadow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        // out-of-range cfg_ch matches no channel, so the commit is a no-op
        assign we[k] = state_q == COMMIT && ch_q == CH_W'(k);

        bool_lut_cell #(.N_IN(N_IN), .INIT(DEFAULT_TT)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we[k]),
            .wdata (shadow_q),
            .idx   (bus.in_data[k*N_IN +: N_IN]),
            .y     (y[k])
        );

`ifdef PROG_BOOL_LUT_HITCNT_EN
        logic [HIT_W-1:0] hit_q, hit_d;

        always_comb
            hit_d = hit_clr ? '0 :
                    (accept && y[k] && hit_q != HIT_MAX) ? hit_q + 1'b1 : hit_q;

        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) hit_q <= '0;
            else        hit_q <= hit_d;

        assign hit_cnt[k*HIT_W +: HIT_W] = hit_q;
`endif
    end

endmodule

// File: tb/tb_prog_bool_lut.sv
// tb_prog_bool_lut: randomized scoreboard bench for prog_bool_lut; covers PROG_BOOL_LUT_HITCNT_EN when defined
module tb_prog_bool_lut;

    localparam int N_IN = 4;
    localparam int N_CH = 2;
    localparam int TT_W = 16;
    localparam int CH_W = 1;
    localparam int DW   = N_CH * N_IN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prog_bool_lut_if #(.N_IN(N_IN), .N_CH(N_CH)) bus ();

`ifdef PROG_BOOL_LUT_HITCNT_EN
    logic               hit_clr = 1'b0;
    logic [N_CH*16-1:0] hit_cnt;
`endif

    prog_bool_lut #(.N_IN(N_IN), .N_CH(N_CH), .DEFAULT_TT(16'hFF91)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef PROG_BOOL_LUT_HITCNT_EN
        ,
        .hit_clr (hit_clr),
        .hit_cnt (hit_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tables as arrays, the serial load as a queue of received bits
    logic [TT_W-1:0] m_tt [N_CH];
    logic [15:0]     m_hit [N_CH];
    logic [N_CH-1:0] exp_q [$];
    bit              m_bits [$];
    int              m_ch = 0;
    bit              m_load = 0, m_commit = 0, m_ov = 0, m_acc;
    logic [N_CH-1:0] m_e;
    logic [TT_W-1:0] m_new;

    initial begin
        for (int k = 0; k < N_CH; k++) begin m_tt[k] = 16'hFF91; m_hit[k] = '0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < N_CH; k++) begin m_tt[k] = 16'hFF91; m_hit[k] = '0; end
                m_load = 0; m_commit = 0; m_ov = 0;
                m_bits.delete();
                exp_q.delete();
            end else begin
                m_acc = bus.in_valid && (!m_ov || bus.out_ready);
                for (int k = 0; k < N_CH; k++) m_e[k] = m_tt[k][bus.in_data[k*N_IN +: N_IN]];
                if (m_acc) exp_q.push_back(m_e);
                m_ov = m_acc || (m_ov && !bus.out_ready);
`ifdef PROG_BOOL_LUT_HITCNT_EN
                for (int k = 0; k < N_CH; k++)
                    if (hit_clr) m_hit[k] = '0;
                    else if (m_acc && m_e[k] && m_hit[k] != 16'hFFFF) m_hit[k] = m_hit[k] + 16'd1;
`endif
                if (m_commit) begin
                    for (int i = 0; i < TT_W; i++) m_new[i] = m_bits[i];
                    if (m_ch < N_CH) m_tt[m_ch] = m_new;
                    m_commit = 0;
                end else if (bus.cfg_start) begin
                    m_load = 1;
                    m_ch = int'(bus.cfg_ch);
                    m_bits.delete();
                end else if (m_load && bus.cfg_bit_valid) begin
                    m_bits.push_back(bus.cfg_bit);
                    if (m_bits.size() == TT_W) begin m_load = 0; m_commit = 1; end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT transfer, checks held data under backpressure
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("out_valid", bus.out_valid, m_ov);
            chk("in_ready", bus.in_ready, !m_ov || bus.out_ready);
            chk("cfg_busy", bus.cfg_busy, m_load || m_commit);
            chk("cfg_done", bus.cfg_done, m_commit);
            if (!rst_n) chk("rst_out_data", bus.out_data, 0);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_data: got %0h with no expected result queued at %0t", bus.out_data, $time);
                end else begin
                    chk("out_data", bus.out_data, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
`ifdef PROG_BOOL_LUT_HITCNT_EN
            for (int k = 0; k < N_CH; k++) chk("hit_cnt", hit_cnt[k*16 +: 16], m_hit[k]);
`endif
        end
    end

    task automatic traffic();
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_data   = DW'($urandom);
        bus.out_ready = $urandom_range(0, 3) != 0;
    endtask

    task automatic sweep(input int ch);
        for (int i = 0; i < TT_W; i++) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            bus.in_data   = DW'($urandom);
            bus.in_data[ch*N_IN +: N_IN] = N_IN'(i);
            @(negedge clk);
        end
    endtask

    task automatic load(input int ch, input logic [TT_W-1:0] tt, input int nbits, input bit gaps);
        bus.cfg_start = 1'b1;
        bus.cfg_ch    = CH_W'(ch);
        traffic();
        @(negedge clk);
        bus.cfg_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                bus.cfg_bit_valid = 1'b0;
                bus.cfg_bit       = 1'($urandom);
                traffic();
                @(negedge clk);
            end
            bus.cfg_bit_valid = 1'b1;
            bus.cfg_bit       = tt[i];
            traffic();
            @(negedge clk);
        end
        bus.cfg_bit_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        bus.cfg_start = 0; bus.cfg_ch = '0; bus.cfg_bit_valid = 0; bus.cfg_bit = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        sweep(0);
        sweep(1);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.in_data = DW'($urandom);
        @(negedge clk);
        repeat (5) begin bus.in_data = DW'($urandom); @(negedge clk); end
        bus.out_ready = 1'b1; bus.in_data = DW'($urandom);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        load(1, 16'h8000, 16, 1);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_data = DW'($urandom); bus.in_data[N_IN +: N_IN] = 4'd14;
        bus.cfg_start = 1'b1; bus.cfg_ch = 1'b0;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        bus.in_data = DW'($urandom); bus.in_data[N_IN +: N_IN] = 4'd14;
        @(negedge clk);
        sweep(1);
        sweep(0);
        load(0, 16'hFFFF, 7, 1);
        load(0, 16'h0001, 16, 1);
        traffic();
        @(negedge clk);
        sweep(0);
        load(1, 16'h1234, 9, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep(0);
        sweep(1);
        repeat (20) begin
            load($urandom_range(0, 1), 16'($urandom), 16, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 6)) begin traffic(); @(negedge clk); end
            sweep($urandom_range(0, 1));
        end
`ifdef PROG_BOOL_LUT_HITCNT_EN
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_data = {4'd0, 4'd15};
        repeat (70000) @(negedge clk);
        chk("hit_sat", hit_cnt[15:0], 16'hFFFF);
        hit_clr = 1'b1;
        @(negedge clk);
        hit_clr = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("hit_clr", hit_cnt[15:0], 16'h0000);
`endif
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_bool_lut.md
Name: prog_bool_lut

Overview:
- Multi-channel, field-programmable boolean function unit. Each channel evaluates an arbitrary N_IN-input function from a stored truth table.
- Replaces hard-wired gate-level boolean blocks.
- Tables reload at runtime through a serial configuration port. Results leave through a registered valid/ready stream.
- Sits between input sampling logic and downstream control consumers.

Parameters:
- N_IN, 4, inputs per channel. Legal range 2..6. TT_W = 2**N_IN.
- N_CH, 2, number of independent channels. Legal range 1..8. CH_W = max(1, clog2(N_CH)).
- DEFAULT_TT, 16'hFF91, TT_W-bit reset table loaded into every channel. The default encodes in0&in1&in2 | ~in0&~in1 | in3.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept input
- in_data  in  N_CH*N_IN  channel k uses bits [k*N_IN +: N_IN]; the index into the table is the bit value
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  N_CH  bit k = table_k[index_k]
- cfg_start  in  1  begin serial load
- cfg_ch  in  CH_W  target channel, sampled with cfg_start
- cfg_bit_valid  in  1  cfg_bit is valid this cycle
- cfg_bit  in  1  table bit, LSB (index 0) first
- cfg_busy  out  1  load in progress
- cfg_done  out  1  one-cycle pulse when the new table commits

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state:
  - out_valid=0, out_data=0, cfg_busy=0, cfg_done=0.
  - All active tables = DEFAULT_TT; shadow register = 0; bit counter = 0; FSM = IDLE.
- Datapath:
  - in_ready = !out_valid | out_ready (combinational).
  - When in_valid & in_ready, out_data and out_valid are registered on the next edge. Latency is 1 cycle.
  - out_valid stays 1 and out_data holds while out_ready=0.
  - out_valid clears when out_ready=1 and there is no new accept.
  - Full throughput: 1 result per cycle when out_ready=1.
- Configuration FSM:
  - IDLE: cfg_start latches cfg_ch, clears the counter and moves to LOAD. cfg_bit_valid is ignored in IDLE.
  - LOAD: each cfg_bit_valid writes cfg_bit into shadow[counter], then counter++.
  - LOAD: when the bit at counter = TT_W-1 is written, move to COMMIT.
  - LOAD: cfg_start restarts the load. Counter returns to 0, the new cfg_ch is latched, and partial shadow contents are discarded.
  - COMMIT (one cycle): active_table[ch] <= shadow; cfg_done=1; return to IDLE.
  - cfg_busy = (state != IDLE).
- Concurrency rules:
  - Evaluation uses the old table during LOAD and COMMIT. An accept in the COMMIT cycle sees the old table; the first accept after COMMIT sees the new one.
  - Other channels are never disturbed.
- Boundary conditions:
  - cfg_ch >= N_CH: the load completes and cfg_done pulses, but no table changes.
  - cfg_start in the COMMIT cycle is ignored.
  - Counter width is clog2(TT_W)+1. No wrap occurs before COMMIT.
  - Reset mid-load aborts the load and restores DEFAULT_TT to every channel.

Optional Feature:
- Macro: PROG_BOOL_LUT_HITCNT_EN.
- Defined:
  - Adds port hit_clr (in, 1) and hit_cnt (out, N_CH*16).
  - Per channel, a 16-bit counter increments on each accepted input whose result bit is 1, saturating at 16'hFFFF.
  - hit_clr zeroes all counters and has priority over increment in the same cycle.
  - Reset value is 0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package prog_bool_lut_pkg holds:
  - the FSM state encoding (IDLE, LOAD, COMMIT);
  - the hit counter width constant (16) and its saturation value;
  - the TT_W/CH_W width helper function.
- One natural sub-module: bool_lut_cell. It contains one channel's active table register, the commit write port and the N_IN-to-1 index mux.
  - It is instantiated N_CH times via generate.
  - The FSM, shadow register and output register stay in the top module.

Test Plan:
- Reset defaults: after reset, drive channel 0 with each in_data index 0..15 -> out_data[0]=1 exactly for indices 0,4,7,8..15; out_valid low until the first accept.
- Backpressure: hold out_ready=0, accept one vector -> out_valid=1, in_ready=0, out_data stable for 5 cycles; raise out_ready with a new in_valid -> next result registered the following cycle, no loss or duplicate.
- Serial load: load 16'h8000 into channel 1 with gaps in cfg_bit_valid -> cfg_busy high throughout; cfg_done pulses once, after the 16th bit plus 1 cycle; index 15 -> 1, index 14 -> 0; channel 0 still follows DEFAULT_TT.
- Commit race: accept a vector in the COMMIT cycle -> its result uses the old table; the vector accepted in the next cycle uses the new table.
- Restart and reset: cfg_start after 7 bits, then a full load of 16'h0001 -> only 16'h0001 is committed. A second load interrupted by rst_n=0 mid-stream -> all tables = 16'hFF91, cfg_busy=0.
- With PROG_BOOL_LUT_HITCNT_EN: 70000 accepts giving result 1 -> hit_cnt saturates at 65535; hit_clr asserted together with a hit -> count reads 0.
